// File: rtl/icebuttons.sv
// icebuttons: memory-mapped input peripheral for board buttons and switches.
// This block is the read-side counterpart of the LED output port.
// Each pin is synchronised, then debounced on clk_enable ticks.
// Rising edges are latched into EDGE and counted in COUNT. MASK gates both.
//
// Register map (word offset from BASE_ADDR; unused upper bits read 0):
//   0 STATE  read-only debounced levels
//   1 EDGE   latched rising edges, write-1-to-clear
//   2 COUNT  16-bit saturating count of masked rising edges; any write clears
//   3 MASK   per-pin edge enable, resets to all-ones
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   clk_enable        one-cycle tick; all architectural state advances only on it
//   read_address      CPU read word address
//   write_address     CPU write word address
//   write_data        CPU write data
//   write_enable      CPU write strobe, qualified by clk_enable
//   pin_in            raw asynchronous board inputs
//   output_data       registered read data, one tick of latency
//   hit               registered: read_address was in range on the last tick
//   irq_pending       OR of all EDGE bits
module icebuttons #(
  parameter int         NUM_INPUTS     = 5,
  parameter int         DEBOUNCE_TICKS = 16,
  parameter logic [7:0] BASE_ADDR      = 8'hF0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic [7:0]            read_address,
  input  logic [7:0]            write_address,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  input  logic [NUM_INPUTS-1:0] pin_in,
  output logic [31:0]           output_data,
  output logic                  hit,
  output logic                  irq_pending
);

  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_EDGE  = 2'd1,
    REG_COUNT = 2'd2,
    REG_MASK  = 2'd3
  } reg_e;

  // The counter is compared against the last value before acceptance.
  // Reaching it while the level still differs is the DEBOUNCE_TICKS-th tick.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

  logic [NUM_INPUTS-1:0]        sync1_q, sync2_q;
  logic [NUM_INPUTS-1:0]        state_q, edge_q, mask_q;
  logic [NUM_INPUTS-1:0][7:0]   cnt_q;
  logic [15:0]                  count_q;

  logic [NUM_INPUTS-1:0]        state_d, edge_d, mask_d, rise, edge_clr;
  logic [NUM_INPUTS-1:0][7:0]   cnt_d;
  logic [15:0]                  count_d;
  logic [16:0]                  count_sum;
  logic [4:0]                   rise_cnt;
  logic                         wr_hit, rd_hit;
  reg_e                         wr_off, rd_off;
  logic [31:0]                  rd_data;
  logic                         unused_wdata;

  // BASE_ADDR is word-aligned to four registers.
  // A match on address bits [7:2] is therefore the exact range check, and it cannot wrap.
  assign wr_hit = write_enable && (write_address[7:2] == BASE_ADDR[7:2]);
  assign rd_hit = (read_address[7:2] == BASE_ADDR[7:2]);
  assign wr_off = reg_e'(write_address[1:0]);
  assign rd_off = reg_e'(read_address[1:0]);

  // Write data above the MASK/EDGE width has no destination.
  assign unused_wdata = ^write_data[31:NUM_INPUTS];

  // Debounce: a differing level must persist for DEBOUNCE_TICKS consecutive ticks.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        state_d[i] = ~state_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // The old MASK gates this tick's edges, even if MASK is being written on the same tick.
  assign rise = state_d & ~state_q & mask_q;

  always_comb begin
    // NOTE: blocking assignments in combinational logic let the loop accumulate in order.
    rise_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rise_cnt = rise_cnt + 5'(rise[i]);
    end
  end

  always_comb begin
    edge_clr  = (wr_hit && wr_off == REG_EDGE) ? write_data[NUM_INPUTS-1:0] : '0;
    // A new edge on a bit wins over a write-1-to-clear of that bit.
    edge_d    = (edge_q & ~edge_clr) | rise;
    count_sum = {1'b0, count_q} + 17'(rise_cnt);
    if (wr_hit && wr_off == REG_COUNT) begin
      count_d = '0;
    end else if (count_sum[16]) begin
      count_d = 16'hFFFF;
    end else begin
      count_d = count_sum[15:0];
    end
    mask_d = (wr_hit && wr_off == REG_MASK) ? write_data[NUM_INPUTS-1:0] : mask_q;
  end

  // Read data is taken from the pre-update registers, so a read sees state before this tick.
  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (rd_off)
        REG_STATE: rd_data = 32'(state_q);
        REG_EDGE:  rd_data = 32'(edge_q);
        REG_COUNT: rd_data = 32'(count_q);
        REG_MASK:  rd_data = 32'(mask_q);
        default:   rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= '0;
      edge_q      <= '0;
      mask_q      <= '1;
      // NOTE: the debounce counters are ordinary flops, not RAM, so they take the reset too.
      cnt_q       <= '0;
      count_q     <= '0;
      output_data <= '0;
      hit         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments model every flop updating together at the edge.
      // The synchroniser runs every clock so that it has settled before the next tick.
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      if (clk_enable) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        edge_q      <= edge_d;
        count_q     <= count_d;
        mask_q      <= mask_d;
        output_data <= rd_data;
        hit         <= rd_hit;
      end
    end
  end

  assign irq_pending = |edge_q;

endmodule

// File: doc/icebuttons.md
Name: icebuttons

Overview:
Memory-mapped input peripheral: the read-direction counterpart of the LED output port in the on-chip memory block. Samples NUM_INPUTS board pins (buttons or switches), synchronises and debounces them, and latches rising edges. Exposes state, edge, press-count and mask registers on the same 8-bit-address, 32-bit-data bus the CPU uses for memory. The top level muxes output_data into the CPU read path when hit is high.

Parameters:
NUM_INPUTS, 5, number of input pins (1..16)
DEBOUNCE_TICKS, 16, consecutive clk_enable ticks an input must hold a new level before it is accepted (2..255)
BASE_ADDR, 8'hF0, word address of register 0; occupies BASE_ADDR..BASE_ADDR+3, BASE_ADDR[1:0] must be 0

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_enable  in  1  one-cycle tick from clock_div; all architectural state advances only on ticks
read_address  in  8  CPU read word address
write_address  in  8  CPU write word address
write_data  in  32  CPU write data
write_enable  in  1  CPU write strobe, qualified by clk_enable
pin_in  in  NUM_INPUTS  raw asynchronous board inputs
output_data  out  32  registered read data
hit  out  1  registered; read_address fell in this block's range on the last tick
irq_pending  out  1  OR of all EDGE bits

Behaviour:
- Reset is asynchronous and active-low: one clock, with reset_n asserted low. On reset:
  - sync flops, STATE, EDGE, COUNT, debounce counters, output_data, hit and irq_pending all go to 0.
  - MASK goes to all-ones (NUM_INPUTS bits).
- Synchroniser: 2-flop per pin, clocked every clk, not gated by clk_enable.
- Debounce, per input, evaluated on each clk_enable tick:
  - If the synced level equals STATE[i], the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_TICKS-1 and the level still differs, STATE[i] toggles and the counter clears. A new level therefore takes exactly DEBOUNCE_TICKS ticks.
  - A glitch that returns before then clears the counter, and STATE is unchanged.
- Rising edge: STATE[i] goes 0->1 on a tick while MASK[i]=1 sets EDGE[i]. Falling edges are ignored.
- Register map (offset = address - BASE_ADDR; unused upper bits read 0):
  - 0 STATE: read-only; writes are ignored.
  - 1 EDGE: write-1-to-clear per bit.
  - 2 COUNT: 16-bit. Increments by the number of masked rising edges on a tick and saturates at 16'hFFFF. Any write clears it.
  - 3 MASK: read/write, NUM_INPUTS bits.
- Writes take effect on a tick where write_enable=1 and write_address is in range.
- Same-tick conflicts:
  - EDGE clear vs. a new edge on the same bit: set wins.
  - COUNT clear vs. an increment: the clear wins and those edges are not counted, but EDGE still captures them.
  - MASK write vs. an edge: the old MASK value gates that tick's edge.
- Read:
  - On each tick, output_data <= register selected by read_address (0 if out of range), and hit <= in-range.
  - Latency is one tick. Between ticks, output_data and hit hold.
  - Read data reflects state before the current tick's updates.
- irq_pending is combinational from EDGE (|EDGE) and is 0 after reset.
- Address wrap: BASE_ADDR+3 must be at most 8'hFF. Out-of-range addresses never alias into the block.
- Reset asserted mid-debounce or mid-read discards all progress immediately. The first tick after release behaves as a fresh start with STATE=0.

Test Plan:
- Reset, then read offsets 0..3 -> 0, 0, 0, 32'h1F with hit=1; read 8'h10 -> output_data=0, hit=0.
- Hold pin_in[2]=1 for 16 ticks -> STATE=32'h4 after tick 16 (not 15), EDGE=32'h4, COUNT=1, irq_pending=1.
- Pulse pin_in[0] high for 10 ticks then low -> STATE, EDGE and COUNT stay 0.
- Pins 1 and 3 rise together and debounce on the same tick -> COUNT+=2 and EDGE=32'hA. Then write 32'h2 to EDGE -> EDGE=32'h8, irq_pending stays 1.
- Write EDGE clear on the same tick a new edge on that bit lands -> bit remains 1. Write COUNT on an increment tick -> COUNT=0 and EDGE bit set.
- MASK=0, then a debounced press -> STATE updates, EDGE and COUNT unchanged. Preload COUNT to 16'hFFFF via repeated presses or force -> further presses stay at 16'hFFFF.
